ipml_fifo_mc: RTL

Parametrised single-clock multi-channel FIFO: c_CH_NUM independent logical FIFOs share one inferred simple-dual-port RAM, each with its own pointers, full/empty, almost flags, water level and sticky overflow/underflow error bits. It is the next generation of the team's single-channel FIFO wrapper. It sits between multi-source capture logic and a shared consumer, for example per-lane packet buffering ahead of the DDR write arbiter. One write and one read of any channels are accepted per cycle, and each read returns its channel tag.

---
 rtl/ipml_fifo_mc_pkg.sv | 32 +++
 rtl/ipml_fifo_mc_if.sv | 44 ++++
 rtl/ipml_fifo_mc_chctrl.sv | 75 +++++++
 rtl/ipml_fifo_mc.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ipml_fifo_mc_pkg.sv
// Shared helpers for the multi-channel FIFO: width derivation, level-field
// slicing and the almost-flag threshold compares.
`timescale 1ns/1ps
package ipml_fifo_mc_pkg;

   localparam int MAX_CH_NUM = 16;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   // A single-channel build still needs a 1-bit channel field.
   function automatic int chWidth(input int chNum);
      return (chNum <= 1) ? 1 : clog2(chNum);
   endfunction

   function automatic int levelLsb(input int ch, input int depthWidth);
      return ch * (depthWidth + 1);
   endfunction

   function automatic logic atOrAbove(input int level, input int threshold);
      return (level >= threshold);
   endfunction

   function automatic logic atOrBelow(input int level, input int threshold);
      return (level <= threshold);
   endfunction

endpackage

// File: rtl/ipml_fifo_mc_if.sv
// Write/read/status bundle of the multi-channel FIFO; the producer side
// drives through 'master', the FIFO itself sits on 'slave'.
`timescale 1ns/1ps
interface ipml_fifo_mc_if
   import ipml_fifo_mc_pkg::*;
#(
   parameter int c_CH_NUM      = 4,
   parameter int c_DEPTH_WIDTH = 9,
   parameter int c_DATA_WIDTH  = 32
);

   localparam int CH_W  = chWidth(c_CH_NUM);
   localparam int LVL_W = c_DEPTH_WIDTH + 1;

   logic                        wr_en;
   logic [CH_W-1:0]             wr_ch;
   logic [c_DATA_WIDTH-1:0]     wr_data;
   logic                        rd_en;
   logic [CH_W-1:0]             rd_ch;
   logic [c_DATA_WIDTH-1:0]     rd_data;
   logic                        rd_valid;
   logic [CH_W-1:0]             rd_ch_out;
   logic [c_CH_NUM-1:0]         wr_full;
   logic [c_CH_NUM-1:0]         rd_empty;
   logic [c_CH_NUM-1:0]         almost_full;
   logic [c_CH_NUM-1:0]         almost_empty;
   logic [c_CH_NUM*LVL_W-1:0]   water_level;
   logic [c_CH_NUM-1:0]         ovf;
   logic [c_CH_NUM-1:0]         udf;
   logic                        err_clr;

   modport master (
      output wr_en, wr_ch, wr_data, rd_en, rd_ch, err_clr,
      input  rd_data, rd_valid, rd_ch_out, wr_full, rd_empty,
             almost_full, almost_empty, water_level, ovf, udf
   );

   modport slave (
      input  wr_en, wr_ch, wr_data, rd_en, rd_ch, err_clr,
      output rd_data, rd_valid, rd_ch_out, wr_full, rd_empty,
             almost_full, almost_empty, water_level, ovf, udf
   );

endinterface

// File: rtl/ipml_fifo_mc_chctrl.sv
// Per-channel bookkeeping: write/read pointers, word count, status flags
// and the sticky overflow/underflow bits for one logical FIFO.
`timescale 1ns/1ps
module ipml_fifo_mc_chctrl
   import ipml_fifo_mc_pkg::*;
#(
   parameter int c_DEPTH_WIDTH      = 9,
   parameter int c_ALMOST_FULL_NUM  = 508,
   parameter int c_ALMOST_EMPTY_NUM = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_we,
   input  logic                     i_re,
   input  logic                     i_wrErr,
   input  logic                     i_rdErr,
   input  logic                     i_errClr,
   output logic [c_DEPTH_WIDTH-1:0] o_wptr,
   output logic [c_DEPTH_WIDTH-1:0] o_rptr,
   output logic [c_DEPTH_WIDTH:0]   o_level,
   output logic                     o_full,
   output logic                     o_empty,
   output logic                     o_almostFull,
   output logic                     o_almostEmpty,
   output logic                     o_ovf,
   output logic                     o_udf
);

   localparam int DEPTH = 1 << c_DEPTH_WIDTH;
   localparam int LVL_W = c_DEPTH_WIDTH + 1;

   logic [c_DEPTH_WIDTH-1:0] r_wptr;
   logic [c_DEPTH_WIDTH-1:0] r_rptr;
   logic [LVL_W-1:0]         r_count;
   logic                     r_ovf;
   logic                     r_udf;

   // A simultaneous write and read of this channel leaves the count as is.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_we) r_wptr <= r_wptr + 1'b1;
         if (i_re) r_rptr <= r_rptr + 1'b1;
         if (i_we && !i_re)      r_count <= r_count + 1'b1;
         else if (i_re && !i_we) r_count <= r_count - 1'b1;
      end
   end

   // An error event in the same cycle as the clear keeps the bit set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (i_wrErr)       r_ovf <= 1'b1;
         else if (i_errClr) r_ovf <= 1'b0;
         if (i_rdErr)       r_udf <= 1'b1;
         else if (i_errClr) r_udf <= 1'b0;
      end
   end

   assign o_wptr        = r_wptr;
   assign o_rptr        = r_rptr;
   assign o_level       = r_count;
   assign o_full        = (r_count == LVL_W'(DEPTH));
   assign o_empty       = (r_count == '0);
   assign o_almostFull  = atOrAbove(int'(r_count), c_ALMOST_FULL_NUM);
   assign o_almostEmpty = atOrBelow(int'(r_count), c_ALMOST_EMPTY_NUM);
   assign o_ovf         = r_ovf;
   assign o_udf         = r_udf;

endmodule

// File: rtl/ipml_fifo_mc.sv
// Multi-channel FIFO: c_CH_NUM logical FIFOs sharing one simple-dual-port
// RAM, with channel decode, read mux and an optional extra output stage.
`timescale 1ns/1ps
module ipml_fifo_mc
   import ipml_fifo_mc_pkg::*;
#(
   parameter int c_CH_NUM           = 4,
   parameter int c_DEPTH_WIDTH      = 9,
   parameter int c_DATA_WIDTH       = 32,
   parameter int c_OUTPUT_REG       = 0,
   parameter int c_ALMOST_FULL_NUM  = 508,
   parameter int c_ALMOST_EMPTY_NUM = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   ipml_fifo_mc_if.slave io_bus
);

   localparam int DEPTH  = 1 << c_DEPTH_WIDTH;
   localparam int CH_W   = chWidth(c_CH_NUM);
   localparam int LVL_W  = c_DEPTH_WIDTH + 1;
   localparam int ADDR_W = CH_W + c_DEPTH_WIDTH;

   logic [c_DEPTH_WIDTH-1:0] w_wptr  [c_CH_NUM];
   logic [c_DEPTH_WIDTH-1:0] w_rptr  [c_CH_NUM];
   logic [LVL_W-1:0]         w_level [c_CH_NUM];
   logic [c_CH_NUM-1:0]      w_we;
   logic [c_CH_NUM-1:0]      w_re;
   logic [c_CH_NUM-1:0]      w_wrErr;
   logic [c_CH_NUM-1:0]      w_rdErr;
   logic [c_CH_NUM-1:0]      w_full;
   logic [c_CH_NUM-1:0]      w_empty;
   logic [c_CH_NUM-1:0]      w_almostFull;
   logic [c_CH_NUM-1:0]      w_almostEmpty;
   logic [c_CH_NUM-1:0]      w_ovf;
   logic [c_CH_NUM-1:0]      w_udf;

   logic                     w_wrAccept;
   logic                     w_rdAccept;
   logic [ADDR_W-1:0]        w_wrAddr;
   logic [ADDR_W-1:0]        w_rdAddr;

   logic [c_DATA_WIDTH-1:0]  r_mem [c_CH_NUM*DEPTH];
   logic                     r_s1Valid;
   logic [c_DATA_WIDTH-1:0]  r_s1Data;
   logic [CH_W-1:0]          r_s1Ch;

   // Out-of-range channel indices match no slice, so they are silently ignored.
   for (genvar c = 0; c < c_CH_NUM; c++) begin : g_ch
      logic w_wrSel;
      logic w_rdSel;

      assign w_wrSel    = io_bus.wr_en && (io_bus.wr_ch == CH_W'(c));
      assign w_rdSel    = io_bus.rd_en && (io_bus.rd_ch == CH_W'(c));
      assign w_we[c]    = w_wrSel && !w_full[c];
      assign w_wrErr[c] = w_wrSel &&  w_full[c];
      assign w_re[c]    = w_rdSel && !w_empty[c];
      assign w_rdErr[c] = w_rdSel &&  w_empty[c];

      ipml_fifo_mc_chctrl #(
         .c_DEPTH_WIDTH      (c_DEPTH_WIDTH),
         .c_ALMOST_FULL_NUM  (c_ALMOST_FULL_NUM),
         .c_ALMOST_EMPTY_NUM (c_ALMOST_EMPTY_NUM)
      ) u_chctrl (
         .clk           (clk),
         .rst_n         (rst_n),
         .i_we          (w_we[c]),
         .i_re          (w_re[c]),
         .i_wrErr       (w_wrErr[c]),
         .i_rdErr       (w_rdErr[c]),
         .i_errClr      (io_bus.err_clr),
         .o_wptr        (w_wptr[c]),
         .o_rptr        (w_rptr[c]),
         .o_level       (w_level[c]),
         .o_full        (w_full[c]),
         .o_empty       (w_empty[c]),
         .o_almostFull  (w_almostFull[c]),
         .o_almostEmpty (w_almostEmpty[c]),
         .o_ovf         (w_ovf[c]),
         .o_udf         (w_udf[c])
      );

      assign io_bus.water_level[levelLsb(c, c_DEPTH_WIDTH) +: LVL_W] = w_level[c];
   end

   assign w_wrAccept = |w_we;
   assign w_rdAccept = |w_re;

   always_comb begin
      w_wrAddr = '0;
      w_rdAddr = '0;
      for (int c = 0; c < c_CH_NUM; c++) begin
         if (w_we[c]) w_wrAddr = {CH_W'(c), w_wptr[c]};
         if (w_re[c]) w_rdAddr = {CH_W'(c), w_rptr[c]};
      end
   end

   always_ff @(posedge clk) begin
      if (w_wrAccept) r_mem[w_wrAddr] <= io_bus.wr_data;
   end

   // The channel tag travels with the word; data only moves on a real read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Valid <= 1'b0;
         r_s1Data  <= '0;
         r_s1Ch    <= '0;
      end else begin
         r_s1Valid <= w_rdAccept;
         if (w_rdAccept) begin
            r_s1Data <= r_mem[w_rdAddr];
            r_s1Ch   <= w_rdAddr[ADDR_W-1 -: CH_W];
         end
      end
   end

   if (c_OUTPUT_REG != 0) begin : g_outReg
      logic                    r_s2Valid;
      logic [c_DATA_WIDTH-1:0] r_s2Data;
      logic [CH_W-1:0]         r_s2Ch;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_s2Valid <= 1'b0;
            r_s2Data  <= '0;
            r_s2Ch    <= '0;
         end else begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
               r_s2Data <= r_s1Data;
               r_s2Ch   <= r_s1Ch;
            end
         end
      end

      assign io_bus.rd_valid  = r_s2Valid;
      assign io_bus.rd_data   = r_s2Data;
      assign io_bus.rd_ch_out = r_s2Ch;
   end else begin : g_noOutReg
      assign io_bus.rd_valid  = r_s1Valid;
      assign io_bus.rd_data   = r_s1Data;
      assign io_bus.rd_ch_out = r_s1Ch;
   end

   assign io_bus.wr_full      = w_full;
   assign io_bus.rd_empty     = w_empty;
   assign io_bus.almost_full  = w_almostFull;
   assign io_bus.almost_empty = w_almostEmpty;
   assign io_bus.ovf          = w_ovf;
   assign io_bus.udf          = w_udf;

endmodule
